// File: rtl/answer_pkg.sv
// answer_pkg: shared states and constants for the answer stabilizer and the display blocks
package answer_pkg;
   typedef enum logic [1:0] {S_ARM, S_TRACK, S_FIRE, S_HOLD} ans_state_t;
   localparam logic [3:0]  DIGIT_NONE = 4'hF;
   localparam logic [10:0] TICK_X     = 11'd640;
   localparam logic [10:0] TICK_Y     = 11'd480;
   localparam logic [3:0]  DIGIT_MAX  = 4'd9;
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-cycle strobe on the first cycle the pixel counters sit at (TICK_X,TICK_Y)
// Ports: i_clk, i_rst_n (async active-low), i_x/i_y pixel counters -> o_tick frame strobe
module frame_tick_gen
   import answer_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [10:0] i_x,
   input  logic [10:0] i_y,
   output logic        o_tick
);
   logic hit, hit_q;
   assign hit = (i_x == TICK_X) && (i_y == TICK_Y);
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) hit_q <= 1'b0;
      else          hit_q <= hit;
   assign o_tick = hit && !hit_q;
endmodule

// File: rtl/answer_stabilizer.sv
// answer_stabilizer: debounces classifier results into one answer event, then locks out during the scroll
// Ports: i_clk, i_rst_n (async active-low), i_x/i_y pixel counters, i_class_valid/i_class_digit classifier
//        result, i_displacement scroll offset -> o_digit_answered, o_digit_identified pulse, o_busy
// Build option: define ANSWER_TIMEOUT_EN to force a blank answer after TIMEOUT_FRAMES idle frames
module answer_stabilizer
   import answer_pkg::*;
#(
   parameter int STABLE_COUNT   = 3,
   parameter int HOLDOFF_FRAMES = 56,
   parameter int TIMEOUT_FRAMES = 600
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [10:0] i_x,
   input  logic [10:0] i_y,
   input  logic        i_class_valid,
   input  logic [3:0]  i_class_digit,
   input  logic [10:0] i_displacement,
   output logic [3:0]  o_digit_answered,
   output logic        o_digit_identified,
   output logic        o_busy
);
   localparam int SW = $clog2(STABLE_COUNT + 1);
   localparam int HW = $clog2(HOLDOFF_FRAMES + 1);
   ans_state_t    state_q, state_d;
   logic [3:0]    cand_q, cand_d, ans_q, ans_d;
   logic [SW-1:0] stable_q, stable_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          id_q, id_d, frame_tick, legal;
`ifdef ANSWER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
   logic [TW-1:0] to_q, to_d;
`endif

   frame_tick_gen u_tick (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_x    (i_x),
      .i_y    (i_y),
      .o_tick (frame_tick)
   );

   assign legal = i_class_valid && (i_class_digit <= DIGIT_MAX);

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      stable_d = stable_q;
      hold_d   = hold_q;
      ans_d    = ans_q;
      id_d     = 1'b0;
      case (state_q)
         S_ARM:
            if (legal) begin
               cand_d   = i_class_digit;
               stable_d = SW'(1);
               state_d  = (STABLE_COUNT == 1) ? S_FIRE : S_TRACK;
            end
         S_TRACK:
            if (i_class_valid && !legal) begin
               stable_d = '0;
               state_d  = S_ARM;
            end else if (legal && i_class_digit == cand_q) begin
               stable_d = (stable_q == SW'(STABLE_COUNT)) ? stable_q : stable_q + 1'b1;
               state_d  = (int'(stable_q) + 1 >= STABLE_COUNT) ? S_FIRE : S_TRACK;
            end else if (legal) begin
               cand_d   = i_class_digit;
               stable_d = SW'(1);
            end
         S_FIRE: begin
            hold_d   = '0;
            stable_d = '0;
            state_d  = S_HOLD;
         end
         default: begin
            hold_d  = (frame_tick && hold_q != HW'(HOLDOFF_FRAMES)) ? hold_q + 1'b1 : hold_q;
            state_d = (hold_q >= HW'(HOLDOFF_FRAMES) && i_displacement == '0) ? S_ARM : S_HOLD;
         end
      endcase
`ifdef ANSWER_TIMEOUT_EN
      to_d = to_q;
      if (state_q == S_ARM || state_q == S_TRACK) begin
         to_d = (frame_tick && to_q != TW'(TIMEOUT_FRAMES)) ? to_q + 1'b1 : to_q;
         // a legal accept already heading to S_FIRE keeps its digit
         if (to_q >= TW'(TIMEOUT_FRAMES) && state_d != S_FIRE) begin
            cand_d  = DIGIT_NONE;
            state_d = S_FIRE;
         end
      end
      if (state_q == S_HOLD && state_d == S_ARM) to_d = '0;
`endif
      // outputs are loaded on the edge into S_FIRE so they are visible during S_FIRE
      if (state_d == S_FIRE) begin
         ans_d = cand_d;
         id_d  = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state_q  <= S_ARM;
         cand_q   <= '0;
         stable_q <= '0;
         hold_q   <= '0;
         ans_q    <= DIGIT_NONE;
         id_q     <= 1'b0;
`ifdef ANSWER_TIMEOUT_EN
         to_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         stable_q <= stable_d;
         hold_q   <= hold_d;
         ans_q    <= ans_d;
         id_q     <= id_d;
`ifdef ANSWER_TIMEOUT_EN
         to_q     <= to_d;
`endif
      end

   assign o_digit_answered   = ans_q;
   assign o_digit_identified = id_q;
   assign o_busy             = (state_q == S_FIRE) || (state_q == S_HOLD);
endmodule

// File: tb/tb_answer_stabilizer.sv
// tb_answer_stabilizer: directed scoreboard bench for answer_stabilizer
module tb_answer_stabilizer;
   logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
   logic [10:0] x = '0, y = '0, disp = '0;
   logic [3:0]  dig = '0, ans;
   logic        ident, busy;
   int          n_assert = 0, n_fail = 0;
   logic [3:0]  sb[$];

   always #5 clk = ~clk;

   answer_stabilizer #(.STABLE_COUNT(3), .HOLDOFF_FRAMES(56), .TIMEOUT_FRAMES(4)) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_x               (x),
      .i_y               (y),
      .i_class_valid     (valid),
      .i_class_digit     (dig),
      .i_displacement    (disp),
      .o_digit_answered  (ans),
      .o_digit_identified(ident),
      .o_busy            (busy)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      if (ident) begin
         chk("pulse_expected", 4'(sb.size() != 0), 4'd1);
         if (sb.size() != 0) chk("answered", ans, sb.pop_front());
      end
   endtask

   task automatic strobe(input logic [3:0] d, input bit fire);
      valid = 1'b1;
      dig   = d;
      if (fire) sb.push_back(d);
      cyc();
      valid = 1'b0;
      if (fire) chk("pulse_latency", 4'(sb.size()), 4'd0);
      cyc();
   endtask

   task automatic frame();
      x = 11'd640; y = 11'd480;
      cyc();
      x = '0; y = '0;
      cyc();
   endtask

   task automatic frames(input int n);
      repeat (n) frame();
   endtask

   task automatic release_hold();
      frames(55);
      chk("busy_hold55", 4'(busy), 4'd1);
      frame();
      cyc();
      chk("busy_after_hold", 4'(busy), 4'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_answered", ans, 4'hF);
      chk("rst_ident", 4'(ident), 4'd0);
      chk("rst_busy", 4'(busy), 4'd0);
      rst_n = 1'b1;
      cyc();
      // 7,7,7 -> answer 7
      strobe(4'd7, 0); strobe(4'd7, 0); strobe(4'd7, 1);
      chk("busy_t1", 4'(busy), 4'd1);
      chk("ans_held_t1", ans, 4'd7);
      release_hold();
      // 4,4,5,5,5 -> answer 5
      strobe(4'd4, 0); strobe(4'd4, 0);
      strobe(4'd5, 0); strobe(4'd5, 0); strobe(4'd5, 1);
      release_hold();
      // 2,2,C,2,2,2 -> answer 2
      strobe(4'd2, 0); strobe(4'd2, 0); strobe(4'hC, 0);
      strobe(4'd2, 0); strobe(4'd2, 0); strobe(4'd2, 1);
      release_hold();
      // holdoff drops strobes; displacement keeps block in hold
      strobe(4'd3, 0); strobe(4'd3, 0); strobe(4'd3, 1);
      strobe(4'd9, 0); strobe(4'd9, 0); strobe(4'd9, 0);
      disp = 11'd30;
      frames(60);
      chk("busy_disp30", 4'(busy), 4'd1);
      chk("ans_held_t4", ans, 4'd3);
      disp = '0;
      cyc(); cyc();
      chk("busy_disp0", 4'(busy), 4'd0);
      strobe(4'd9, 0); strobe(4'd9, 0); strobe(4'd9, 1);
      release_hold();
      // idle frames: timeout fires a blank answer only when enabled
`ifdef ANSWER_TIMEOUT_EN
      sb.push_back(4'hF);
      frames(4);
      cyc();
      chk("timeout_pulse", 4'(sb.size()), 4'd0);
      chk("busy_timeout", 4'(busy), 4'd1);
      release_hold();
`else
      frames(4);
      cyc(); cyc();
      chk("no_timeout_busy", 4'(busy), 4'd0);
      chk("no_timeout_ans", ans, 4'd9);
`endif
      // async reset in S_TRACK
      strobe(4'd1, 0); strobe(4'd1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_answered", ans, 4'hF);
      chk("arst_ident", 4'(ident), 4'd0);
      chk("arst_busy", 4'(busy), 4'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      strobe(4'd1, 0);
      cyc(); cyc(); cyc();
      chk("post_rst_busy", 4'(busy), 4'd0);
      chk("post_rst_ans", ans, 4'hF);
      chk("scoreboard_empty", 4'(sb.size()), 4'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
